// File: rtl/shift_pkg.sv
// shift_pkg: widths and the request command shared by the shift request stage, its FIFO and the bench.
package shift_pkg;
  localparam int DATA_W = 8;
  localparam int SHAMT_W = 3;
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               right;
  } shift_cmd_t;
endpackage

// File: rtl/shift_req_fifo.sv
// shift_req_fifo: synchronous DEPTH-entry request FIFO with occupancy count.
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  shift_cmd_t   din_i,
  input  logic         pop_i,
  output shift_cmd_t   dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  shift_cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full_o = cnt_q == (AW+1)'(DEPTH);
    empty_o = cnt_q == '0;
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_o = mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/shift_req_stage.sv
// shift_req_stage: queues shift requests, issues them to a combinational shifter
// from registers and captures its result one cycle later behind a valid/ready port.
module shift_req_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic               req_right,
  output logic [DATA_W-1:0]  sh_data,
  output logic [SHAMT_W-1:0] sh_sel,
  output logic               sh_right,
  input  logic [DATA_W-1:0]  sh_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [CW-1:0]      fifo_count
);
  shift_cmd_t req_cmd, head, sh_q, sh_d;
  logic fifo_full, fifo_empty, pop, cap_en;
  logic iss_valid_q, iss_valid_d, res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  shift_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid),
    .din_i   (req_cmd),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  // The issue slot frees up in the same cycle its command moves into the result register.
  always_comb begin
    req_cmd = '{data: req_data, shamt: req_shamt, right: req_right};
    req_ready = !fifo_full;
    cap_en = iss_valid_q && (!res_valid_q || res_ready);
    pop = !fifo_empty && (!iss_valid_q || cap_en);
    sh_d = pop ? head : sh_q;
    iss_valid_d = pop ? 1'b1 : cap_en ? 1'b0 : iss_valid_q;
    res_valid_d = cap_en ? 1'b1 : res_ready ? 1'b0 : res_valid_q;
    res_data_d = cap_en ? sh_result : res_data_q;
    sh_data = sh_q.data;
    sh_sel = sh_q.shamt;
    sh_right = sh_q.right;
    res_valid = res_valid_q;
    res_data = res_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      iss_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      sh_q <= sh_d;
      iss_valid_q <= iss_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
    end
  end
endmodule

// File: tb/tb_shift_req_stage.sv
// tb_shift_req_stage: scoreboard bench driving shift_req_stage with a behavioural shifter on sh_*.
module tb_shift_req_stage;
  import shift_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_right = 1'b0, res_valid, res_ready = 1'b0, sh_right;
  logic [DATA_W-1:0] req_data = '0, sh_data, sh_result, res_data;
  logic [SHAMT_W-1:0] req_shamt = '0, sh_sel;
  logic [2:0] fifo_count;
  logic [DATA_W-1:0] exp_q [$];
  int n_cmp = 0, n_err = 0, n_acc = 0, n_res = 0;

  shift_req_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_shamt(req_shamt), .req_right(req_right),
    .sh_data(sh_data), .sh_sel(sh_sel), .sh_right(sh_right), .sh_result(sh_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .fifo_count(fifo_count)
  );

  assign sh_result = sh_right ? sh_data >> sh_sel : sh_data << sh_sel;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record both handshakes that will fire on the coming edge, then advance to the next falling edge.
  task automatic step();
    logic [DATA_W-1:0] e;
    if (req_valid && req_ready) begin
      e = req_right ? req_data >> req_shamt : req_data << req_shamt;
      exp_q.push_back(e);
      n_acc++;
    end
    if (res_valid && res_ready) begin
      n_res++;
      if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 32'd1);
      else chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic [7:0] d, input logic [2:0] s, input logic r);
    req_valid = v; req_data = d; req_shamt = s; req_right = r;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || res_valid); i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(n_res), 32'(n_acc));
  endtask

  task automatic directed(input logic [7:0] d, input logic [2:0] s, input logic r, input logic [7:0] exp);
    set_req(1'b1, d, s, r);
    res_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("lat_cnt_e0", 32'(fifo_count), 32'd1);
    chk("lat_e0", 32'(res_valid), 32'd0);
    step();
    chk("lat_e1", 32'(res_valid), 32'd0);
    step();
    chk("lat_e2", 32'(res_valid), 32'd1);
    chk("lat_value", 32'(res_data), 32'(exp));
    step();
    chk("lat_after", 32'(res_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sh_data", 32'(sh_data), 32'd0);
    chk("rst_sh_sel", 32'(sh_sel), 32'd0);
    chk("rst_sh_right", 32'(sh_right), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    directed(8'hB5, 3'd3, 1'b1, 8'h16);
    directed(8'hB5, 3'd3, 1'b0, 8'hA8);
    directed(8'hB5, 3'd0, 1'b1, 8'hB5);
    directed(8'hB5, 3'd0, 1'b0, 8'hB5);
    directed(8'h81, 3'd7, 1'b1, 8'h01);
    directed(8'h81, 3'd7, 1'b0, 8'h80);

    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, 8'($urandom), 3'($urandom), 1'($urandom));
      chk("stream_ready", 32'(req_ready), 32'd1);
      step();
      if (i >= 2) chk("stream_valid", 32'(res_valid), 32'd1);
    end
    drain();

    res_ready = 1'b0;
    n_acc = 0; n_res = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 8'($urandom), 3'($urandom), 1'($urandom));
      step();
    end
    chk("bp_accepted", 32'(n_acc), 32'd6);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_count", 32'(fifo_count), 32'd4);
    res_ready = 1'b1;
    step();
    chk("full_pop_no_push", 32'(n_acc), 32'd6);
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    drain();

    n_acc = 0; n_res = 0;
    for (int i = 0; i < 1000; i++) begin
      set_req(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
      res_ready = 1'($urandom);
      step();
    end
    drain();

    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 8'($urandom), 3'($urandom), 1'($urandom));
      step();
    end
    req_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_sh", 32'({sh_data, sh_sel, sh_right}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale", 32'(res_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
